// File: rtl/instr_classifier_pkg.sv
// Shared instruction definitions for the MIPS pipeline.
// Holds the ID enumeration, format/func codes and the widths that go with them.
package instr_classifier_pkg;

    localparam int WIDTH_INSTR  = 6;
    localparam int WIDTH_FORMAT = 2;
    localparam int WIDTH_FUNC   = 3;

    typedef enum logic [WIDTH_INSTR-1:0] {
        INSTR_NOP   = 6'd0,
        INSTR_ADDU  = 6'd1,
        INSTR_SUBU  = 6'd2,
        INSTR_ADD   = 6'd3,
        INSTR_SUB   = 6'd4,
        INSTR_AND   = 6'd5,
        INSTR_OR    = 6'd6,
        INSTR_XOR   = 6'd7,
        INSTR_NOR   = 6'd8,
        INSTR_SLT   = 6'd9,
        INSTR_SLTU  = 6'd10,
        INSTR_SLL   = 6'd11,
        INSTR_SRL   = 6'd12,
        INSTR_SRA   = 6'd13,
        INSTR_SLLV  = 6'd14,
        INSTR_SRLV  = 6'd15,
        INSTR_SRAV  = 6'd16,
        INSTR_ADDI  = 6'd17,
        INSTR_ADDIU = 6'd18,
        INSTR_ANDI  = 6'd19,
        INSTR_ORI   = 6'd20,
        INSTR_XORI  = 6'd21,
        INSTR_LUI   = 6'd22,
        INSTR_SLTI  = 6'd23,
        INSTR_SLTIU = 6'd24,
        INSTR_LW    = 6'd25,
        INSTR_LH    = 6'd26,
        INSTR_LHU   = 6'd27,
        INSTR_LB    = 6'd28,
        INSTR_LBU   = 6'd29,
        INSTR_SW    = 6'd30,
        INSTR_SH    = 6'd31,
        INSTR_SB    = 6'd32,
        INSTR_BEQ   = 6'd33,
        INSTR_BNE   = 6'd34,
        INSTR_BLEZ  = 6'd35,
        INSTR_BGTZ  = 6'd36,
        INSTR_BLTZ  = 6'd37,
        INSTR_BGEZ  = 6'd38,
        INSTR_J     = 6'd39,
        INSTR_JAL   = 6'd40,
        INSTR_JR    = 6'd41,
        INSTR_JALR  = 6'd42,
        INSTR_MULT  = 6'd43,
        INSTR_MULTU = 6'd44,
        INSTR_DIV   = 6'd45,
        INSTR_DIVU  = 6'd46,
        INSTR_MFHI  = 6'd47,
        INSTR_MFLO  = 6'd48,
        INSTR_MTHI  = 6'd49,
        INSTR_MTLO  = 6'd50
    } instr_e;

    typedef enum logic [WIDTH_FORMAT-1:0] {
        FORMAT_R    = 2'd0,
        FORMAT_I    = 2'd1,
        FORMAT_J    = 2'd2,
        FORMAT_NONE = 2'd3
    } format_e;

    typedef enum logic [WIDTH_FUNC-1:0] {
        FUNC_OTHER     = 3'd0,
        FUNC_CALC_R    = 3'd1,
        FUNC_CALC_I    = 3'd2,
        FUNC_MEM_READ  = 3'd3,
        FUNC_MEM_WRITE = 3'd4,
        FUNC_BRANCH    = 3'd5,
        FUNC_JUMP      = 3'd6,
        FUNC_MULDIV    = 3'd7
    } func_e;

    // IDs above the last enumerated instruction have no defined meaning.
    function automatic logic instr_is_defined(input logic [WIDTH_INSTR-1:0] id);
        return id <= INSTR_MTLO;
    endfunction

endpackage

// File: rtl/instr_classifier_if.sv
// Classifier bus: the instruction ID going in and its classification coming out.
interface instr_classifier_if
    import instr_classifier_pkg::*;
    ;

    logic [WIDTH_INSTR-1:0] instr;
    format_e                format;
    func_e                  func;
    logic                   illegal;

    modport master (
        output instr,
        input  format,
        input  func,
        input  illegal
    );

    modport slave (
        input  instr,
        output format,
        output func,
        output illegal
    );

endinterface

// File: rtl/instr_class_lut.sv
// Combinational instruction ID -> format/func/illegal lookup.
// Also used unregistered by pipeline stages that need classification in the same cycle.
module instr_class_lut
    import instr_classifier_pkg::*;
(
    input  logic [WIDTH_INSTR-1:0] instr,
    output format_e                format,
    output func_e                  func,
    output logic                   illegal
);

    // NOP and undefined IDs fall through to NONE/OTHER; only undefined IDs are illegal.
    always_comb begin
        format  = FORMAT_NONE;
        func    = FUNC_OTHER;
        illegal = !instr_is_defined(instr);

        case (instr) inside
            [INSTR_ADDU:INSTR_SRAV]: begin
                format = FORMAT_R;
                func   = FUNC_CALC_R;
            end
            [INSTR_ADDI:INSTR_SLTIU]: begin
                format = FORMAT_I;
                func   = FUNC_CALC_I;
            end
            [INSTR_LW:INSTR_LBU]: begin
                format = FORMAT_I;
                func   = FUNC_MEM_READ;
            end
            [INSTR_SW:INSTR_SB]: begin
                format = FORMAT_I;
                func   = FUNC_MEM_WRITE;
            end
            [INSTR_BEQ:INSTR_BGEZ]: begin
                format = FORMAT_I;
                func   = FUNC_BRANCH;
            end
            [INSTR_J:INSTR_JAL]: begin
                format = FORMAT_J;
                func   = FUNC_JUMP;
            end
            // Register jumps use the R encoding even though they are jumps.
            [INSTR_JR:INSTR_JALR]: begin
                format = FORMAT_R;
                func   = FUNC_JUMP;
            end
            [INSTR_MULT:INSTR_MTLO]: begin
                format = FORMAT_R;
                func   = FUNC_MULDIV;
            end
            default: begin
                format = FORMAT_NONE;
                func   = FUNC_OTHER;
            end
        endcase
    end

endmodule

// File: rtl/instr_classifier.sv
// Registered instruction classifier: one-cycle-latency wrapper around instr_class_lut.
module instr_classifier
    import instr_classifier_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    instr_classifier_if.slave  bus
);

    format_e lut_format;
    func_e   lut_func;
    logic    lut_illegal;

    instr_class_lut u_lut (
        .instr   (bus.instr),
        .format  (lut_format),
        .func    (lut_func),
        .illegal (lut_illegal)
    );

    // Reset wins over a new ID on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.format  <= FORMAT_NONE;
            bus.func    <= FUNC_OTHER;
            bus.illegal <= 1'b0;
        end else begin
            bus.format  <= lut_format;
            bus.func    <= lut_func;
            bus.illegal <= lut_illegal;
        end
    end

endmodule

// File: tb/tb_instr_classifier.sv
// Self-checking bench for instr_classifier: directed vectors plus a range-table model checked every cycle.
module tb_instr_classifier;

    logic       clk;
    logic       reset;
    int         num_checks;
    int         num_errors;
    logic [7:0] func_seen;

    instr_classifier_if bus_if ();

    instr_classifier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First ID of each func group 1..7, then the first undefined ID.
    function automatic int model_func(input int id);
        int group_start[8] = '{1, 17, 25, 30, 33, 39, 43, 51};
        int result = 0;
        if (id == 0 || id >= 51) return 0;
        for (int k = 0; k < 7; k++)
            if (id >= group_start[k]) result = k + 1;
        return result;
    endfunction

    function automatic int model_format(input int id);
        int f = model_func(id);
        if (f == 0) return 3;
        if (f == 1 || f == 7) return 0;
        if (f == 6) return (id <= 40) ? 2 : 0;
        return 1;
    endfunction

    int   exp_id;
    int   exp_format;
    int   exp_func;
    int   exp_illegal;
    logic model_valid = 1'b0;

    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (!reset) begin
            exp_id      <= -1;
            exp_format  <= 3;
            exp_func    <= 0;
            exp_illegal <= 0;
        end else begin
            exp_id      <= int'(bus_if.instr);
            exp_format  <= model_format(int'(bus_if.instr));
            exp_func    <= model_func(int'(bus_if.instr));
            exp_illegal <= (int'(bus_if.instr) > 50) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            num_checks++;
            if (int'(bus_if.format) != exp_format || int'(bus_if.func) != exp_func ||
                int'(bus_if.illegal) != exp_illegal) begin
                num_errors++;
                $display("[TB] FAIL model id=%0d: got format=%0d func=%0d illegal=%0d, expected %0d/%0d/%0d",
                         exp_id, bus_if.format, bus_if.func, bus_if.illegal,
                         exp_format, exp_func, exp_illegal);
            end else if (reset && exp_id >= 0) begin
                func_seen[bus_if.func] = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input logic rst_val, input int id);
        @(negedge clk);
        reset        = rst_val;
        bus_if.instr = id[5:0];
    endtask

    task automatic checkOutput(input string name, input int f, input int fn, input int il);
        num_checks++;
        if (int'(bus_if.format) != f || int'(bus_if.func) != fn || int'(bus_if.illegal) != il) begin
            num_errors++;
            $display("[TB] FAIL %s: got format=%0d func=%0d illegal=%0d, expected %0d/%0d/%0d",
                     name, bus_if.format, bus_if.func, bus_if.illegal, f, fn, il);
        end
    endtask

    initial begin
        num_checks   = 0;
        num_errors   = 0;
        func_seen    = '0;
        reset        = 1'b0;
        bus_if.instr = 6'd30;

        applyStimulus(0, 30);
        applyStimulus(0, 30);
        applyStimulus(1, 30);
        checkOutput("reset_state", 3, 0, 0);
        applyStimulus(1, 25);
        checkOutput("first_after_reset_sw", 1, 4, 0);

        applyStimulus(1, 30);
        checkOutput("stream_lw", 1, 3, 0);
        applyStimulus(1, 33);
        checkOutput("stream_sw", 1, 4, 0);
        applyStimulus(1, 39);
        checkOutput("stream_beq", 1, 5, 0);
        applyStimulus(1, 41);
        checkOutput("stream_j", 2, 6, 0);
        applyStimulus(1, 43);
        checkOutput("stream_jr", 0, 6, 0);
        applyStimulus(1, 0);
        checkOutput("stream_mult", 0, 7, 0);

        applyStimulus(1, 51);
        checkOutput("nop", 3, 0, 0);
        applyStimulus(1, 63);
        checkOutput("undef_51", 3, 0, 1);
        applyStimulus(1, 1);
        checkOutput("undef_63", 3, 0, 1);

        applyStimulus(0, 1);
        checkOutput("addu_before_reset", 0, 1, 0);
        applyStimulus(1, 1);
        checkOutput("midstream_reset", 3, 0, 0);
        applyStimulus(1, 17);
        checkOutput("addu_after_reset", 0, 1, 0);
        applyStimulus(1, 24);
        checkOutput("addi_lo_edge", 1, 2, 0);
        applyStimulus(1, 50);
        checkOutput("sltiu_hi_edge", 1, 2, 0);
        applyStimulus(1, 0);
        checkOutput("mtlo_last_legal", 0, 7, 0);

        for (int i = 0; i < 64; i++)
            applyStimulus(1, i);
        applyStimulus(1, 0);
        applyStimulus(1, 0);

        num_checks++;
        if (func_seen != 8'hFF) begin
            num_errors++;
            $display("[TB] FAIL func_coverage: got seen mask=%b, expected 11111111", func_seen);
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/instr_classifier.md
# instr_classifier

Registered instruction classifier for the MIPS pipeline: maps a pre-decoded instruction ID to its encoding format and functional class. Downstream units, e.g. the data memory write enable (`func == FUNC_MEM_WRITE`), key off these outputs instead of enumerating IDs. One instance per pipeline stage that needs classification.

## Interface
- Parameters: none. Widths come from the shared package: `WIDTH_INSTR`=6, `WIDTH_FORMAT`=2, `WIDTH_FUNC`=3.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low (asserted when 0).
- `instr`  in  `WIDTH_INSTR`  instruction ID from the shared enumeration.
- `format`  out  `WIDTH_FORMAT`  encoding format of the registered ID.
- `func`  out  `WIDTH_FUNC`  functional class of the registered ID.
- `illegal`  out  1  high when the registered ID is outside 0..50.

## Operation
- Instruction ID enumeration, values 0..50:
  - 0 NOP.
  - ALU register-register: 1 ADDU, 2 SUBU, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU.
  - Shifts: 11 SLL, 12 SRL, 13 SRA, 14 SLLV, 15 SRLV, 16 SRAV.
  - ALU immediate: 17 ADDI, 18 ADDIU, 19 ANDI, 20 ORI, 21 XORI, 22 LUI, 23 SLTI, 24 SLTIU.
  - Loads: 25 LW, 26 LH, 27 LHU, 28 LB, 29 LBU.
  - Stores: 30 SW, 31 SH, 32 SB.
  - Branches: 33 BEQ, 34 BNE, 35 BLEZ, 36 BGTZ, 37 BLTZ, 38 BGEZ.
  - Jumps: 39 J, 40 JAL, 41 JR, 42 JALR.
  - Multiply/divide and HI/LO: 43 MULT, 44 MULTU, 45 DIV, 46 DIVU, 47 MFHI, 48 MFLO, 49 MTHI, 50 MTLO.
  - 51..63 are undefined.
- Format codes: `FORMAT_R`=0, `FORMAT_I`=1, `FORMAT_J`=2, `FORMAT_NONE`=3.
  - R: IDs 1–16, 41–50.
  - I: IDs 17–38.
  - J: IDs 39–40.
  - NONE: NOP and undefined IDs.
- Func codes:
  - `FUNC_OTHER`=0: NOP and undefined IDs.
  - `FUNC_CALC_R`=1: IDs 1–16.
  - `FUNC_CALC_I`=2: IDs 17–24.
  - `FUNC_MEM_READ`=3: IDs 25–29.
  - `FUNC_MEM_WRITE`=4: IDs 30–32.
  - `FUNC_BRANCH`=5: IDs 33–38.
  - `FUNC_JUMP`=6: IDs 39–42.
  - `FUNC_MULDIV`=7: IDs 43–50.
- `illegal`=1 only for IDs 51..63. For those IDs `format`=NONE and `func`=OTHER. NOP is legal (`illegal`=0).
- The mapping is a pure function of `instr`. There is no other state.

## Timing
- Outputs are registered, with 1-cycle latency: the values reflect the `instr` sampled at the previous rising edge.
- Reset is checked at the rising edge while `reset`==0. Reset values:
  - `format`=`FORMAT_NONE` (3)
  - `func`=`FUNC_OTHER` (0)
  - `illegal`=0
- Reset has priority over a new `instr` at the same edge. The first classification appears one cycle after the edge at which `reset` returns to 1.
- Back-to-back IDs produce back-to-back classifications with no bubbles.
- No enable and no handshake: a new ID is accepted every cycle.

## Structure
- Shared package (instructions/format/func definitions) holds:
  - the ID enumeration constants;
  - `FORMAT_*` and `FUNC_*` codes;
  - the width constants.
- DM and other consumers import the same package.
- A single combinational sub-module `instr_class_lut` (`instr` -> `format`/`func`/`illegal`) feeds the output register. Other pipeline stages reuse it directly where they need unregistered classification.

## Test plan
- Hold `reset`=0 for 2 edges with `instr`=30 (SW) -> `format`=3, `func`=0, `illegal`=0. Release reset -> next edge gives `format`=1, `func`=4.
- Stream 25, 30, 33, 39, 41, 43 on consecutive cycles -> one cycle later, in order:
  - 25: `format`/`func` = 1/3
  - 30: 1/4
  - 33: 1/5
  - 39: 2/6
  - 41: 0/6
  - 43: 0/7
- `instr`=0 (NOP) -> `format`=3, `func`=0, `illegal`=0. `instr`=51 and `instr`=63 -> `format`=3, `func`=0, `illegal`=1.
- Drive `reset`=0 mid-stream while `instr`=1 -> outputs go to 3/0/0 at that edge, not 0/1.
- Exhaustive sweep of 0..63 -> compare each registered output against a bench model of the ranges above. All 64 IDs must be covered, and each of the 8 func codes must be hit.
